pair_sum_sched: RTL and testbench

PAIR_SUM_SCHED -- requirements
Module: pair_sum_sched

---
 rtl/pair_sum_pkg.sv | 18 +
 rtl/pair_sum_sched_rr_arb2.sv | 42 ++++
 rtl/pair_sum_sched.sv | 132 +++++++++++++
 tb/tb_pair_sum_sched.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pair_sum_pkg.sv
// Shared types for pair_sum_sched: arbiter pointer encoding, requester index, ignore-counter width.
// Pure declarations, no logic or latency.
package pair_sum_pkg;

   typedef enum logic {
      RR0 = 1'b0,
      RR1 = 1'b1
   } rr_state_e;

   typedef logic req_idx_t;

   localparam int IGN_CNT_W = 8;

   function automatic logic [IGN_CNT_W-1:0] sat_inc(input logic [IGN_CNT_W-1:0] v);
      return (v == '1) ? v : v + {{(IGN_CNT_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/pair_sum_sched_rr_arb2.sv
// Two-requester round-robin arbiter with combinational grants and a registered pointer.
// No backpressure of its own: clr and rst suppress all grants for that cycle.
module rr_arb2
   import pair_sum_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      clr,
   input  logic      req0,
   input  logic      req1,
   input  logic      hs_acc,
   output logic      gnt0,
   output logic      gnt1,
   output rr_state_e ptr
);

   rr_state_e ptr_q, ptr_d;

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst && !clr) begin
         gnt0 = req0 && ((ptr_q == RR0) || !req1);
         gnt1 = req1 && ((ptr_q == RR1) || !req0);
      end
   end

   // After serving one requester, favour the other one.
   always_comb begin
      ptr_d = ptr_q;
      if (hs_acc && gnt0)      ptr_d = RR1;
      else if (hs_acc && gnt1) ptr_d = RR0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= RR0;
      else     ptr_q <= ptr_d;
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/pair_sum_sched.sv
// Arbitrates two sample requesters and outputs last_i + d_i one cycle after each consumed sample.
// Optional macro PAIR_SUM_IGNCNT_EN adds saturating per-requester counters of discarded IGN samples.
module pair_sum_sched
   import pair_sum_pkg::*;
#(
   parameter int          W   = 4,
   parameter int unsigned IGN = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         req0,
   input  logic         req1,
   input  logic [W-1:0] d0,
   input  logic [W-1:0] d1,
   output logic         gnt0,
   output logic         gnt1,
   output logic [W:0]   q,
   output logic         q_vld,
   output logic         q_src
`ifdef PAIR_SUM_IGNCNT_EN
   ,
   output logic [IGN_CNT_W-1:0] ign_cnt0,
   output logic [IGN_CNT_W-1:0] ign_cnt1
`endif
);

   localparam logic [W-1:0] IGN_V = W'(IGN);

   rr_state_e    ptr;
   logic         hs;
   req_idx_t     src;
   logic [W-1:0] d_sel, last_sel;

   logic [W-1:0] last0_q, last0_d, last1_q, last1_d;
   logic [W:0]   q_q, q_d;
   logic         q_vld_q, q_vld_d;
   req_idx_t     q_src_q, q_src_d;

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .req0   (req0),
      .req1   (req1),
      .hs_acc (hs),
      .gnt0   (gnt0),
      .gnt1   (gnt1),
      .ptr    (ptr)
   );

   // Every grant is consumed on the same edge, so the grant itself is the handshake.
   assign hs       = gnt0 | gnt1;
   assign src      = gnt1;
   assign d_sel    = src ? d1 : d0;
   assign last_sel = src ? last1_q : last0_q;

   always_comb begin
      last0_d = last0_q;
      last1_d = last1_q;
      q_d     = q_q;
      q_src_d = q_src_q;
      q_vld_d = 1'b0;
      if (clr) begin
         last0_d = '0;
         last1_d = '0;
      end else if (hs && (d_sel != IGN_V)) begin
         q_d     = {1'b0, last_sel} + {1'b0, d_sel};
         q_src_d = src;
         q_vld_d = 1'b1;
         if (src) last1_d = d_sel;
         else     last0_d = d_sel;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last0_q <= '0;
         last1_q <= '0;
         q_q     <= '0;
         q_vld_q <= 1'b0;
         q_src_q <= 1'b0;
      end else begin
         last0_q <= last0_d;
         last1_q <= last1_d;
         q_q     <= q_d;
         q_vld_q <= q_vld_d;
         q_src_q <= q_src_d;
      end
   end

   assign q     = q_q;
   assign q_vld = q_vld_q;
   assign q_src = q_src_q;

`ifdef PAIR_SUM_IGNCNT_EN
   logic                 ign_hit;
   logic [IGN_CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

   assign ign_hit = hs && (d_sel == IGN_V);

   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (clr) begin
         cnt0_d = '0;
         cnt1_d = '0;
      end else if (ign_hit) begin
         if (src) cnt1_d = sat_inc(cnt1_q);
         else     cnt0_d = sat_inc(cnt0_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign ign_cnt0 = cnt0_q;
   assign ign_cnt1 = cnt1_q;
`endif

   // Under contention the favoured requester must be the one granted.
   a_contention_follows_ptr: assert property (@(posedge clk) disable iff (rst)
      (req0 && req1 && !clr) |-> (gnt1 == (ptr == RR1)));

endmodule

// File: tb/tb_pair_sum_sched.sv
// Randomized scoreboard bench for pair_sum_sched plus directed boundary sequences.
module tb_pair_sum_sched;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, clr, req0, req1;
   logic [3:0] d0, d1;
   logic       gnt0, gnt1, q_vld, q_src;
   logic [4:0] q;
`ifdef PAIR_SUM_IGNCNT_EN
   logic [7:0] ign_cnt0, ign_cnt1;
`endif

   pair_sum_sched #(.W(4), .IGN(0)) u_dut (
      .clk(clk), .rst(rst), .clr(clr), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
      .gnt0(gnt0), .gnt1(gnt1), .q(q), .q_vld(q_vld), .q_src(q_src)
`ifdef PAIR_SUM_IGNCNT_EN
      , .ign_cnt0(ign_cnt0), .ign_cnt1(ign_cnt1)
`endif
   );

   // Wider instance for the 8-bit width boundary.
   logic       b_rst, b_clr, b_req0, b_req1;
   logic [7:0] b_d0, b_d1;
   logic       b_gnt0, b_gnt1, b_q_vld, b_q_src;
   logic [8:0] b_q;
`ifdef PAIR_SUM_IGNCNT_EN
   logic [7:0] b_ign_cnt0, b_ign_cnt1;
`endif

   pair_sum_sched #(.W(8), .IGN(0)) u_dut8 (
      .clk(clk), .rst(b_rst), .clr(b_clr), .req0(b_req0), .req1(b_req1), .d0(b_d0), .d1(b_d1),
      .gnt0(b_gnt0), .gnt1(b_gnt1), .q(b_q), .q_vld(b_q_vld), .q_src(b_q_src)
`ifdef PAIR_SUM_IGNCNT_EN
      , .ign_cnt0(b_ign_cnt0), .ign_cnt1(b_ign_cnt1)
`endif
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      int q;
      int src;
      int tag;
   } exp_t;

   exp_t sb[$];
   int   seen_q[$];
   int   seen_src[$];
   int   cyc = 0;
   int   hold_q = 0;
   int   hold_src = 0;

   // Reference model state: who is favoured and each requester's last valid sample.
   int   fav = 0;
   int   last[2] = '{0, 0};

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a new result.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            if (q_vld) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL spurious_q_vld actual=%0d required=no_result", q);
               end else begin
                  e = sb.pop_front();
                  chk("q", int'(q), e.q);
                  chk("q_src", int'(q_src), e.src);
                  chk("q_latency", cyc, e.tag);
                  hold_q   = e.q;
                  hold_src = e.src;
               end
               seen_q.push_back(int'(q));
               seen_src.push_back(int'(q_src));
            end else begin
               chk("q_hold", int'(q), hold_q);
               chk("q_src_hold", int'(q_src), hold_src);
            end
         end
         cyc++;
      end
   end

   // Drives one cycle starting at posedge+1; returns at the next posedge+1.
   task automatic drive(input logic r0, input logic r1, input logic [3:0] v0, input logic [3:0] v1,
                        input logic c, output logic took0, output logic took1);
      logic g0, g1;
      int   i, v;
      req0 = r0; req1 = r1; d0 = v0; d1 = v1; clr = c;
      #3;
      g0 = !c && r0 && (fav == 0 || !r1);
      g1 = !c && r1 && (fav == 1 || !r0);
      chk("gnt0", int'(gnt0), int'(g0));
      chk("gnt1", int'(gnt1), int'(g1));
      if (g0 || g1) begin
         i = g0 ? 0 : 1;
         v = g0 ? int'(v0) : int'(v1);
         if (v != 0) begin
            sb.push_back('{last[i] + v, i, cyc});
            last[i] = v;
         end
         fav = 1 - i;
      end
      if (c) last = '{0, 0};
      took0 = g0;
      took1 = g1;
      @(posedge clk);
      #1;
   endtask

   task automatic mid_reset();
      req0 = 1'b1; req1 = 1'b1; clr = 1'b0; d0 = 4'd1; d1 = 4'd1;
      #2;
      rst = 1'b1;
      #1;
      chk("rst_q", int'(q), 0);
      chk("rst_q_vld", int'(q_vld), 0);
      chk("rst_gnt0", int'(gnt0), 0);
      chk("rst_gnt1", int'(gnt1), 0);
      sb.delete();
      fav = 0; last = '{0, 0}; hold_q = 0; hold_src = 0;
      @(posedge clk);
      #2;
      rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
      @(posedge clk);
      #1;
      seen_q.delete();
      seen_src.delete();
   endtask

   task automatic chk_seen(input string name, input int idx, input int exp_q, input int exp_src);
      chk({name, "_q"},   (seen_q.size() > idx)   ? seen_q[idx]   : -1, exp_q);
      chk({name, "_src"}, (seen_src.size() > idx) ? seen_src[idx] : -1, exp_src);
   endtask

   logic       t0, t1, p0, p1, c;
   logic [3:0] v0, v1;
   int         took0_log[$];

   initial begin
      rst = 1'b1; clr = 1'b0; req0 = 1'b0; req1 = 1'b0; d0 = '0; d1 = '0;
      b_rst = 1'b1; b_clr = 1'b0; b_req0 = 1'b0; b_req1 = 1'b0; b_d0 = '0; b_d1 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("init_q", int'(q), 0);
      chk("init_q_vld", int'(q_vld), 0);
      rst = 1'b0; b_rst = 1'b0;

      // Reset mid-cycle, then d0=2 is summed against a cleared last0.
      drive(1'b1, 1'b0, 4'd6, 4'd0, 1'b0, t0, t1);
      mid_reset();
      drive(1'b1, 1'b0, 4'd2, 4'd0, 1'b0, t0, t1);
      drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, t0, t1);
      chk_seen("post_rst", 0, 2, 0);

      // Single requester with an ignored sample in the middle.
      mid_reset();
      drive(1'b1, 1'b0, 4'd7, 4'd0, 1'b0, t0, t1);
      drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, t0, t1);
      drive(1'b1, 1'b0, 4'd3, 4'd0, 1'b0, t0, t1);
      drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, t0, t1);
      chk_seen("single0", 0, 7, 0);
      chk_seen("single1", 1, 10, 0);
      chk("single_count", seen_q.size(), 2);

      // Contention: both held high, grants alternate.
      mid_reset();
      took0_log.delete();
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 1'b1, 4'd5, 4'd9, 1'b0, t0, t1);
         took0_log.push_back(int'(gnt0 === 1'bx ? 0 : t0));
      end
      drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, t0, t1);
      chk_seen("cont0", 0, 5, 0);
      chk_seen("cont1", 1, 9, 1);
      chk_seen("cont2", 2, 10, 0);
      chk_seen("cont3", 3, 18, 1);

      // Width boundary at W=4 on requester 1.
      mid_reset();
      drive(1'b0, 1'b1, 4'd0, 4'd15, 1'b0, t0, t1);
      drive(1'b0, 1'b1, 4'd0, 4'd15, 1'b0, t0, t1);
      drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, t0, t1);
      chk_seen("wide4", 1, 30, 1);

      // Width boundary at W=8.
      b_req1 = 1'b1; b_d1 = 8'd255;
      #3;
      chk("w8_gnt1", int'(b_gnt1), 1);
      @(posedge clk);
      #1;
      chk("w8_first", int'(b_q), 255);
      @(posedge clk);
      #1;
      b_req1 = 1'b0;
      chk("w8_q", int'(b_q), 510);
      chk("w8_src", int'(b_q_src), 1);
      chk("w8_vld", int'(b_q_vld), 1);

      // clr collides with a pending request.
      mid_reset();
      drive(1'b1, 1'b0, 4'd7, 4'd0, 1'b0, t0, t1);
      drive(1'b1, 1'b0, 4'd4, 4'd0, 1'b1, t0, t1);
      drive(1'b1, 1'b0, 4'd4, 4'd0, 1'b0, t0, t1);
      drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, t0, t1);
      chk_seen("clr0", 0, 7, 0);
      chk_seen("clr1", 1, 4, 0);

`ifdef PAIR_SUM_IGNCNT_EN
      mid_reset();
      for (int k = 0; k < 300; k++) drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, t0, t1);
      chk("ign_cnt0_sat", int'(ign_cnt0), 255);
      chk("ign_cnt1_zero", int'(ign_cnt1), 0);
      drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, t0, t1);
      chk("ign_cnt0_clr", int'(ign_cnt0), 0);
      chk("ign_cnt1_clr", int'(ign_cnt1), 0);
`endif

      // Randomized traffic: each requester holds its sample until granted.
      mid_reset();
      p0 = 1'b0; p1 = 1'b0; v0 = '0; v1 = '0;
      for (int n = 0; n < 2000; n++) begin
         if (!p0) begin
            p0 = ($urandom_range(0, 3) != 0);
            v0 = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         end
         if (!p1) begin
            p1 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         end
         c = ($urandom_range(0, 11) == 0);
         drive(p0, p1, v0, v1, c, t0, t1);
         if (t0) p0 = 1'b0;
         if (t1) p1 = 1'b0;
         if (n % 500 == 250) mid_reset();
      end
      drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, t0, t1);
      drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, t0, t1);
      chk("sb_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
